// File: rtl/bfm_adder_pkg.sv
// rtl/bfm_adder_pkg.sv - shared constants and types for the bfm_adder slice
//
// Purpose: default operand width, the deepest supported pipeline, and the
//          byte operand type used by the adder and its harness.
// Ports:   none (package).

package bfm_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_LATENCY   = 8;

    typedef logic [7:0] byte_t;

endpackage : bfm_adder_pkg

// File: rtl/bfm_adder_delay.sv
// rtl/bfm_adder_delay.sv - fixed-depth shift register with asynchronous clear
//
// Purpose: delays a data word by DEPTH rising edges, one word per cycle,
//          with no stall; every stage clears immediately on i_rst.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high clear of all stages
//   i_data  word entering the first stage
//   o_data  word leaving the last stage (DEPTH edges after entry)

module bfm_adder_delay #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule : bfm_adder_delay

// File: rtl/bfm_adder.sv
// rtl/bfm_adder.sv - free-running registered unsigned adder with fixed latency
//
// Purpose: samples A_s and B_s every rising edge and presents their
//          modulo-2^WIDTH sum plus carry LATENCY edges later.
// Ports:
//   clk_i    rising-edge system clock
//   reset_i  asynchronous active-high reset; clears every pipeline stage
//   A_s      operand A, unsigned
//   B_s      operand B, unsigned
//   res_o    registered sum[WIDTH-1:0]
//   carry_o  registered sum[WIDTH], aligned with res_o

module bfm_adder
    import bfm_adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] A_s,
    input  logic [WIDTH-1:0] B_s,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("bfm_adder: LATENCY must be within 1..%0d", MAX_LATENCY);
        end
    endgenerate

    // Widen before adding so the carry lands in the top bit.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, A_s} + {1'b0, B_s};

    // First stage: the sampling register, present for every latency.
    logic [WIDTH:0] r_sum;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    logic [WIDTH:0] w_out;

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_out = r_sum;
        end else begin : g_delayed
            // Carry travels with the sum so the two stay aligned.
            bfm_adder_delay #(
                .WIDTH (WIDTH + 1),
                .DEPTH (LATENCY - 1)
            ) u_delay (
                .i_clk  (clk_i),
                .i_rst  (reset_i),
                .i_data (r_sum),
                .o_data (w_out)
            );
        end
    endgenerate

    assign res_o   = w_out[WIDTH-1:0];
    assign carry_o = w_out[WIDTH];

endmodule : bfm_adder

// File: tb/tb_bfm_adder.sv
// tb/tb_bfm_adder.sv - self-checking bench for bfm_adder at latencies 1, 3 and 8

module tb_bfm_adder;
    import bfm_adder_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    byte_t a;
    byte_t b;

    byte_t res1, res3, res8;
    logic  c1, c3, c8;

    always #5 clk = ~clk;

    bfm_adder #(.WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .A_s(a), .B_s(b), .res_o(res1), .carry_o(c1));
    bfm_adder #(.WIDTH(8), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .reset_i(rst), .A_s(a), .B_s(b), .res_o(res3), .carry_o(c3));
    bfm_adder #(.WIDTH(8), .LATENCY(8)) u_dut8 (
        .clk_i(clk), .reset_i(rst), .A_s(a), .B_s(b), .res_o(res8), .carry_o(c8));

    int checks = 0;
    int errors = 0;

    // Reference: full 9-bit sum sampled at each edge number; anything sampled
    // at or before floor_e was wiped by a reset and reads as zero.
    int v [0:16383];
    int n       = 0;
    int floor_e = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at edge %0d", tag, got, exp, n);
        end
    endtask

    function automatic logic [31:0] model(input int lat);
        int idx;
        idx = n - lat + 1;
        if (idx <= floor_e) return 32'd0;
        return 32'(v[idx] % 512);
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_l1"}, 32'({c1, res1}), model(1));
        check({tag, "_l3"}, 32'({c3, res3}), model(3));
        check({tag, "_l8"}, 32'({c8, res8}), model(8));
    endtask

    // Drive operands, take one rising edge, then look half a period later.
    task automatic edge_step(input byte_t na, input byte_t nb, input string tag);
        a = na;
        b = nb;
        @(posedge clk);
        n++;
        if (rst) begin
            v[n]    = 0;
            floor_e = n;
        end else begin
            v[n] = int'(na) + int'(nb);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    byte_t wrap_a [3] = '{8'd200, 8'd255, 8'd255};
    byte_t wrap_b [3] = '{8'd100, 8'd255, 8'd1};
    int    wrap_e [3] = '{300, 510, 256};
    byte_t str_a  [4] = '{8'd1, 8'd3, 8'd250, 8'd0};
    byte_t str_b  [4] = '{8'd2, 8'd4, 8'd10,  8'd0};
    int    str_e  [4] = '{3, 7, 260, 0};

    initial begin
        rst = 1'b1;
        a   = 8'd5;
        b   = 8'd7;
        #1;
        check("reset_initial", 32'({c1, res1}), 32'd0);

        for (int i = 0; i < 3; i++) edge_step(8'd5, 8'd7, "reset_hold");

        rst = 1'b0;
        edge_step(8'd5, 8'd7, "basic");
        check("basic_sum", 32'({c1, res1}), 32'd12);

        for (int i = 0; i < 3; i++) begin
            edge_step(wrap_a[i], wrap_b[i], "wrap");
            check("wrap_sum", 32'({c1, res1}), 32'(wrap_e[i]));
        end

        for (int i = 0; i < 4; i++) begin
            edge_step(str_a[i], str_b[i], "stream");
            check("stream_sum", 32'({c1, res1}), 32'(str_e[i]));
        end

        for (int i = 0; i < 8; i++) edge_step(8'd0, 8'd0, "flush");
        edge_step(8'd10, 8'd20, "lat_pulse");
        check("lat3_k0", 32'({c3, res3}), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            edge_step(8'd0, 8'd0, "lat_tail");
            check("lat3_window", 32'({c3, res3}), (k == 2) ? 32'd30 : 32'd0);
        end

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                for (int j = 0; j < 8; j++) edge_step(8'd200, 8'd100, "pre_pulse");
                #1 rst = 1'b1;
                #2;
                check("async_clear_l1", 32'({c1, res1}), 32'd0);
                check("async_clear_l3", 32'({c3, res3}), 32'd0);
                check("async_clear_l8", 32'({c8, res8}), 32'd0);
                floor_e = n;
                #1 rst = 1'b0;
            end
            edge_step(byte_t'($urandom), byte_t'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bfm_adder

// File: doc/bfm_adder.md
Name: bfm_adder

Overview:
- Registered unsigned adder used as the bus-functional model behind the streaming adder harness.
- Each clock it samples two byte operands and, after a fixed pipeline latency, presents their modulo-2^WIDTH sum.
- Operands change every cycle with no handshake; it is a free-running, always-accepting datapath.
- It sits directly below the stimulus wrapper, which streams operand pairs and prints the sum one half-period after each edge.

Parameters:
- WIDTH, 8, operand and result width in bits.
- LATENCY, 1, clock edges from operand sampling to result visible on res_o; legal range 1..8.

Ports:
- clk_i  input  1  single system clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- A_s  input  WIDTH  operand A, unsigned.
- B_s  input  WIDTH  operand B, unsigned.
- res_o  output  WIDTH  registered sum (A_s + B_s) mod 2^WIDTH.
- carry_o  output  1  carry-out of the same sum, aligned with res_o; may be left unconnected.

Behaviour:
- Interface: one clock (clk_i); reset_i is asynchronous and active-high.
- Reset: assertion immediately clears every pipeline register, so res_o = 0 and carry_o = 0 without waiting for a clock edge. Values stay 0 while reset_i is high. Release takes effect at the next rising edge.
- Arithmetic: compute sum = A_s + B_s in WIDTH+1 bits.
  - res_o = sum[WIDTH-1:0]; carry_o = sum[WIDTH].
  - Unsigned only; wrap-around is silent, for example 200 + 100 gives res_o = 44 and carry_o = 1.
- Sampling: A_s and B_s are captured at a rising edge, using the values present just before that edge.
- Timing: with LATENCY = 1, res_o reflects the operands sampled at edge N from edge N until edge N+1. A reader sampling half a period after edge N therefore sees the sum of the operands that were stable before edge N.
- LATENCY > 1: the result passes through LATENCY-1 further register stages. Throughput is one result per cycle, with no bubbles and no stall input.
- Reset mid-stream: every in-flight result is discarded. The first valid result appears LATENCY edges after the first post-reset sampling edge. Until then res_o reads 0.
- Held operands: if the operands are constant, res_o is constant after LATENCY edges.
- No X-propagation special handling: X on an input gives X on the output after LATENCY edges.
- Combinational paths: none from inputs to outputs.

Decomposition:
- Shared package bfm_adder_pkg holds:
  - constant DEFAULT_WIDTH = 8;
  - constant MAX_LATENCY = 8;
  - typedef byte_t as logic [7:0].
- One natural sub-module, bfm_adder_delay: a parameterised WIDTH+1-bit shift register with asynchronous active-high clear.
  - Instantiated once to carry {carry, sum} through LATENCY-1 extra stages.
  - Generate-bypassed when LATENCY = 1.
- Parameter checking: an elaboration-time assertion rejects LATENCY outside 1..8.

Test Plan:
- Reset: hold reset_i high, drive A_s = 5, B_s = 7 for 3 edges -> res_o = 0 and carry_o = 0 throughout. Assert reset_i between edges -> res_o drops to 0 before the next edge.
- Basic sum: release reset, drive A_s = 5, B_s = 7 before an edge -> half a period after that edge res_o = 12, carry_o = 0.
- Wrap: A_s = 200, B_s = 100 -> res_o = 44, carry_o = 1. A_s = 255, B_s = 255 -> res_o = 254, carry_o = 1. A_s = 255, B_s = 1 -> res_o = 0, carry_o = 1.
- Streaming: change operands every cycle with the pairs (1,2), (3,4), (250,10), (0,0) -> res_o = 3, 7, 4, 0 on consecutive cycles, with carry_o = 0, 0, 1, 0.
- Latency: set LATENCY = 3, apply a single pair (10,20) then (0,0) -> res_o = 30 appears exactly 3 edges after sampling and holds for one cycle only.
- Mid-stream reset: stream a random 10 000-pair sequence and pulse reset_i for half a cycle in the middle -> outputs clear asynchronously. Post-reset results match a reference model (A + B) mod 256, offset by LATENCY, with zero mismatches.
